// File: rtl/nubus_master_pkg.sv
// NuBus master shared definitions: FSM states, ack status codes,
// transfer-mask helpers.
package nubus_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  // Ack status as seen on the inverted {tm1n,tm0n} lines
  localparam logic [1:0] TMN_COMPLETE = 2'b11;
  localparam logic [1:0] TMN_ERROR    = 2'b10;
  localparam logic [1:0] TMN_TIMEOUT  = 2'b01;
  localparam logic [1:0] TMN_TRYAGAIN = 2'b00;

  function automatic logic mask_legal(input logic [3:0] m);
    logic ok;
    case (m)
      4'h0, 4'hF,
      4'h3, 4'hC,
      4'h1, 4'h2,
      4'h4, 4'h8: ok = 1'b1;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [1:0] lane_lo(input logic [3:0] m);
    logic [1:0] lo;
    case (m)
      4'h2:       lo = 2'd1;
      4'h4, 4'hC: lo = 2'd2;
      4'h8:       lo = 2'd3;
      default:    lo = 2'd0;
    endcase
    return lo;
  endfunction

endpackage

// File: rtl/nubus_master_wdt.sv
// Data-phase watchdog: counts enabled cycles, flags the cycle
// that reaches the all-ones count.
module nubus_mst_wdt #(
  parameter int W = 8
) (
  input  logic nub_clkn,
  input  logic nub_resetn,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [W-1:0] cnt;
  logic [W-1:0] inc;

  assign inc = cnt + W'(1);
  assign tc  = enable & (&inc);

  always_ff @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= inc;
    end
  end

endmodule

// File: rtl/nubus_master.sv
// NuBus bus master: CPU request to NuBus arbitration, address
// and data phases, with retry, watchdog and locked ownership.
module nubus_master
  import nubus_master_pkg::*;
#(
  parameter int WDT_W     = 8,
  parameter int RETRY_MAX = 3
) (
  input  logic        nub_clkn,
  input  logic        nub_resetn,
  input  logic        nub_startn,
  input  logic        nub_ackn,
  input  logic        nub_tm1n,
  input  logic        nub_tm0n,
  input  logic [31:0] nub_adn,
  input  logic        grant,
  output logic        arb,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_write,
  input  logic        cpu_lock,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        cpu_error,
  output logic        cpu_tryagain,
  output logic        mst_arbcyn,
  output logic        mst_adrcyn,
  output logic        mst_dtacyn,
  output logic        mst_ownern,
  output logic        mst_lockedn,
  output logic        mst_tm1n,
  output logic        mst_tm0n,
  output logic        mst_timeout,
  output logic        mst_adoe,
  output logic [31:0] mst_ad
);

  localparam int RW = $clog2(RETRY_MAX + 2);

  state_t state;
  state_t state_nxt;

  logic [31:2]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    mask_q;
  logic          lock_q;
  logic          owned;
  logic          err_q;
  logic          ta_q;
  logic          ill_q;
  logic [RW-1:0] retry_q;

  logic       wdt_tc;
  logic       acked;
  logic       is_read;
  logic       legal;
  logic       retry_ok;
  logic       bus_own;
  logic [1:0] status;
  logic       unused;

  assign acked    = ~nub_ackn;
  assign is_read  = (mask_q == 4'h0);
  assign legal    = mask_legal(cpu_write);
  assign status   = {nub_tm1n, nub_tm0n};
  assign retry_ok = (retry_q < RW'(RETRY_MAX));
  assign unused   = ^cpu_addr[1:0];

  nubus_mst_wdt #(
    .W(WDT_W)
  ) u_wdt (
    .nub_clkn  (nub_clkn),
    .nub_resetn(nub_resetn),
    .clear     (state != S_DATA),
    .enable    (state == S_DATA),
    .tc        (wdt_tc)
  );

  always_ff @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (cpu_valid) begin
          if (!legal) begin
            state_nxt = S_DONE;
          end else if (owned) begin
            state_nxt = S_ADDR;
          end else begin
            state_nxt = S_ARB;
          end
        end
      end
      S_ARB: begin
        if (grant && nub_startn && nub_ackn) begin
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: state_nxt = S_DATA;
      S_DATA: begin
        if (acked) begin
          if (status == TMN_TRYAGAIN && retry_ok) begin
            // a held bus skips re-arbitration
            state_nxt = (lock_q || owned) ? S_ADDR : S_ARB;
          end else begin
            state_nxt = S_DONE;
          end
        end else if (wdt_tc) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      lock_q    <= 1'b0;
      owned     <= 1'b0;
      err_q     <= 1'b0;
      ta_q      <= 1'b0;
      ill_q     <= 1'b0;
      retry_q   <= '0;
      cpu_rdata <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cpu_valid) begin
            addr_q  <= cpu_addr[31:2];
            wdata_q <= cpu_wdata;
            mask_q  <= cpu_write;
            lock_q  <= cpu_lock;
            ill_q   <= ~legal;
            err_q   <= ~legal;
            ta_q    <= 1'b0;
            retry_q <= '0;
          end else begin
            owned <= 1'b0;
          end
        end
        S_DATA: begin
          if (acked) begin
            if (is_read) begin
              cpu_rdata <= ~nub_adn;
            end
            if (status == TMN_TRYAGAIN) begin
              if (retry_ok) begin
                retry_q <= retry_q + RW'(1);
              end else begin
                ta_q <= 1'b1;
              end
            end else begin
              err_q <= (status != TMN_COMPLETE);
            end
          end else if (wdt_tc) begin
            err_q <= 1'b1;
          end
        end
        S_DONE: begin
          // a rejected request never gains ownership
          owned <= lock_q & (owned | ~ill_q);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    arb          = 1'b0;
    mst_arbcyn   = 1'b1;
    mst_adrcyn   = 1'b1;
    mst_dtacyn   = 1'b1;
    mst_tm1n     = 1'b1;
    mst_tm0n     = 1'b1;
    mst_timeout  = 1'b0;
    mst_adoe     = 1'b0;
    mst_ad       = '0;
    cpu_ready    = 1'b0;
    cpu_error    = 1'b0;
    cpu_tryagain = 1'b0;
    bus_own      = 1'b0;
    unique case (state)
      S_ARB: begin
        arb        = 1'b1;
        mst_arbcyn = 1'b0;
      end
      S_ADDR: begin
        mst_adrcyn = 1'b0;
        mst_adoe   = 1'b1;
        mst_ad     = {addr_q, lane_lo(mask_q)};
        mst_tm1n   = ~|mask_q;
        mst_tm0n   = (mask_q == 4'hF) || is_read;
        bus_own    = 1'b1;
      end
      S_DATA: begin
        mst_dtacyn  = 1'b0;
        mst_adoe    = ~is_read;
        mst_ad      = is_read ? 32'h0 : wdata_q;
        mst_timeout = wdt_tc & nub_ackn;
        bus_own     = 1'b1;
      end
      S_DONE: begin
        cpu_ready    = 1'b1;
        cpu_error    = err_q;
        cpu_tryagain = ta_q;
        bus_own      = ~ill_q;
      end
      default: ;
    endcase
    mst_ownern  = ~(bus_own | owned);
    mst_lockedn = ~(owned | (bus_own & lock_q));
  end

endmodule
